// File: rtl/svm_pkg.sv
// Shared widths, state encoding and defaults for the SVM decision stage.
// Fixed-point formats: accumulator s8c13f, score s9c13f.
package svm_pkg;

  localparam int ACC_W   = 22;
  localparam int SCORE_W = 23;
  localparam int FRAC    = 13;

  localparam int                      DEF_N_FEAT = 64;
  localparam logic signed [ACC_W-1:0] DEF_BIAS   = '0;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_SCORE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/svm_decision.sv
// Sequencer for the external SVM accumulator: counts terms, adds the bias to the
// finished dot product, thresholds at zero and clears the accumulator per vector.
module svm_decision
  import svm_pkg::*;
#(
  parameter int                      N_FEAT = DEF_N_FEAT,
  parameter logic signed [ACC_W-1:0] BIAS   = DEF_BIAS,
  parameter int                      CW     = $clog2(N_FEAT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prod_valid,
  input  logic                      prod_last,
  output logic                      prod_ready,
  input  logic                      abort,
  input  logic signed [ACC_W-1:0]   acc_y,
  output logic                      acc_ce,
  output logic                      acc_rst,
  output logic signed [SCORE_W-1:0] score,
  output logic                      is_car,
  output logic                      out_valid,
  output logic                      frame_err
);

  state_t                     state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic signed [SCORE_W-1:0]  score_q, score_d;
  logic                       is_car_q, is_car_d;
  logic                       out_valid_q, out_valid_d;
  logic                       frame_err_q, frame_err_d;

  logic                       accept;
  logic                       at_last_cnt;
  logic signed [SCORE_W-1:0]  sum_p0;

  // Sign-extend both operands by one bit so the sum can never wrap.
  function automatic logic signed [SCORE_W-1:0] add_bias(
    input logic signed [ACC_W-1:0] y
  );
    logic signed [SCORE_W-1:0] y_ext, b_ext;
    y_ext = {y[ACC_W-1], y};
    b_ext = {BIAS[ACC_W-1], BIAS};
    return y_ext + b_ext;
  endfunction

  assign prod_ready  = ~rst & (state_q == ST_ACC);
  assign accept      = prod_valid & prod_ready;
  assign at_last_cnt = (count_q == CW'(N_FEAT - 1));
  assign sum_p0      = add_bias(acc_y);

  // Reset clears the accumulator in the same cycle it is asserted.
  assign acc_rst = rst | (state_q == ST_CLEAR);
  assign acc_ce  = rst | (state_q == ST_CLEAR) |
                   ((state_q == ST_ACC) & prod_valid & ~abort);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    score_d     = score_q;
    is_car_d    = is_car_q;
    out_valid_d = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_ACC: begin
        if (abort) begin
          state_d = ST_CLEAR;
        end else if (accept) begin
          count_d = count_q + 1'b1;
          if (prod_last && at_last_cnt) begin
            state_d = ST_SCORE;
          end else if (prod_last || at_last_cnt) begin
            frame_err_d = 1'b1;
            state_d     = ST_CLEAR;
          end
        end
      end
      ST_SCORE: begin
        score_d     = sum_p0;
        is_car_d    = ~sum_p0[SCORE_W-1];
        out_valid_d = 1'b1;
        state_d     = ST_CLEAR;
      end
      ST_CLEAR: begin
        count_d = '0;
        state_d = ST_ACC;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      score_q     <= '0;
      is_car_q    <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      score_q     <= score_d;
      is_car_q    <= is_car_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign score     = score_q;
  assign is_car    = is_car_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_svm_decision.sv
// Bench for svm_decision: three instances with different biases share one term stream,
// each driving its own behavioural accumulator; results are scored against plain sums.
module tb_svm_decision;
  import svm_pkg::*;

  localparam int NF = 4;
  localparam int NI = 3;
  localparam logic signed [ACC_W-1:0] B0 = 22'sd0;
  localparam logic signed [ACC_W-1:0] B1 = 22'sd8192;
  localparam logic signed [ACC_W-1:0] B2 = 22'sh1FFFFF;

  int bias_v [NI] = '{0, 8192, 2097151};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prod_valid = 1'b0;
  logic prod_last = 1'b0;
  logic abort = 1'b0;
  logic signed [16:0] prod_data = '0;

  logic [NI-1:0] prod_ready, acc_ce, acc_rst, is_car, out_valid, frame_err;
  logic signed [ACC_W-1:0]   acc_q [NI];
  logic signed [SCORE_W-1:0] score [NI];

  always #5 clk = ~clk;

  svm_decision #(.N_FEAT(NF), .BIAS(B0)) u0 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready[0]), .abort(abort), .acc_y(acc_q[0]), .acc_ce(acc_ce[0]),
    .acc_rst(acc_rst[0]), .score(score[0]), .is_car(is_car[0]),
    .out_valid(out_valid[0]), .frame_err(frame_err[0]));

  svm_decision #(.N_FEAT(NF), .BIAS(B1)) u1 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready[1]), .abort(abort), .acc_y(acc_q[1]), .acc_ce(acc_ce[1]),
    .acc_rst(acc_rst[1]), .score(score[1]), .is_car(is_car[1]),
    .out_valid(out_valid[1]), .frame_err(frame_err[1]));

  svm_decision #(.N_FEAT(NF), .BIAS(B2)) u2 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready[2]), .abort(abort), .acc_y(acc_q[2]), .acc_ce(acc_ce[2]),
    .acc_rst(acc_rst[2]), .score(score[2]), .is_car(is_car[2]),
    .out_valid(out_valid[2]), .frame_err(frame_err[2]));

  // Behavioural acc_svm: clear wins over add, both gated by ce.
  always @(posedge clk)
    for (int j = 0; j < NI; j++)
      if (acc_ce[j])
        acc_q[j] <= acc_rst[j] ? '0 : acc_q[j] + {{(ACC_W-17){prod_data[16]}}, prod_data};

  int ov_tot [NI] = '{0, 0, 0};
  int ce_tot [NI] = '{0, 0, 0};
  always @(negedge clk)
    for (int j = 0; j < NI; j++) begin
      if (out_valid[j]) ov_tot[j] <= ov_tot[j] + 1;
      if (acc_ce[j] && !acc_rst[j]) ce_tot[j] <= ce_tot[j] + 1;
    end

  int n_cmp = 0;
  int n_fail = 0;
  int ov_snap [NI];
  int ce_snap [NI];
  int exp_score [NI] = '{0, 0, 0};
  int exp_car [NI] = '{0, 0, 0};
  int exp_ferr = 0;
  int tv [4];

  typedef struct {
    int n; int last_idx; int gap; bit abrt;
    int t0; int t1; int t2; int t3;
    bit good; bit mal; int sum;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int j = 0; j < NI; j++) begin
      ov_snap[j] = ov_tot[j];
      ce_snap[j] = ce_tot[j];
    end
  endtask

  task automatic send_term(input int v, input bit last, input int gap);
    int waited;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    repeat (gap) tick();
    prod_valid = 1'b1;
    prod_data  = 17'(v);
    prod_last  = last;
    waited = 0;
    while (prod_ready[0] !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    if (waited >= 8) chk("prod_ready timeout", 0, 1);
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic run_vec(input int n, input int last_idx, input int max_gap, input bit do_abort);
    snap();
    for (int i = 0; i < n; i++)
      send_term(tv[i], i == last_idx,
                (max_gap > 0 && i > 0) ? int'($urandom_range(max_gap, 1)) : 0);
    if (do_abort) begin
      prod_valid = 1'b1;
      prod_data  = 17'(tv[n]);
      abort      = 1'b1;
      tick();
      abort      = 1'b0;
      prod_valid = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic check_vec(input string tag, input bit good, input int sum, input int n_acc);
    for (int j = 0; j < NI; j++) begin
      if (good) begin
        exp_score[j] = sum + bias_v[j];
        exp_car[j]   = (exp_score[j] >= 0) ? 1 : 0;
      end
      chk($sformatf("%s/u%0d out_valid pulses", tag, j), ov_tot[j] - ov_snap[j], good ? 1 : 0);
      chk($sformatf("%s/u%0d score", tag, j), int'(score[j]), exp_score[j]);
      chk($sformatf("%s/u%0d is_car", tag, j), int'(is_car[j]), exp_car[j]);
      chk($sformatf("%s/u%0d frame_err", tag, j), int'(frame_err[j]), exp_ferr);
      chk($sformatf("%s/u%0d acc cleared", tag, j), int'(acc_q[j]), 0);
      chk($sformatf("%s/u%0d terms added", tag, j), ce_tot[j] - ce_snap[j], n_acc);
    end
  endtask

  initial begin
    int kind, n, sum;
    tbl[0] = '{4,  3, 0, 1'b0, -4096, -4096, -4096, -4096, 1'b1, 1'b0, -16384};
    tbl[1] = '{4,  3, 0, 1'b0, -2048, -2048, -2048, -2048, 1'b1, 1'b0, -8192};
    tbl[2] = '{4,  3, 3, 1'b0,  8192,  8192,  8192,  8192, 1'b1, 1'b0, 32768};
    tbl[3] = '{3,  2, 0, 1'b0,  8192,  8192,  8192,     0, 1'b0, 1'b1, 0};
    tbl[4] = '{4,  3, 1, 1'b0,   100,  -200,   300,    50, 1'b1, 1'b0, 250};
    tbl[5] = '{2, -1, 0, 1'b1,  8192,  8192,   999,     0, 1'b0, 1'b0, 0};
    tbl[6] = '{4,  3, 0, 1'b0, 65535, 65535, 65535, 65535, 1'b1, 1'b0, 262140};
    tbl[7] = '{4, -1, 0, 1'b0,     1,     2,     3,     4, 1'b0, 1'b1, 0};

    // Reset: accumulator cleared while rst is high, outputs zero afterwards.
    repeat (2) tick();
    chk("reset acc_rst", int'(acc_rst[0]), 1);
    chk("reset acc_ce", int'(acc_ce[0]), 1);
    rst = 1'b0;
    tick();
    for (int j = 0; j < NI; j++) begin
      chk($sformatf("reset/u%0d score", j), int'(score[j]), 0);
      chk($sformatf("reset/u%0d is_car", j), int'(is_car[j]), 0);
      chk($sformatf("reset/u%0d out_valid", j), int'(out_valid[j]), 0);
      chk($sformatf("reset/u%0d frame_err", j), int'(frame_err[j]), 0);
      chk($sformatf("reset/u%0d acc", j), int'(acc_q[j]), 0);
    end
    chk("reset prod_ready", int'(prod_ready[0]), 1);

    // Back-to-back positive vector with cycle-exact handshake checks.
    snap();
    for (int i = 0; i < 4; i++) send_term(8192, i == 3, 0);
    chk("score-cycle prod_ready", int'(prod_ready[0]), 0);
    chk("score-cycle acc_ce", int'(acc_ce[0]), 0);
    chk("score-cycle out_valid", int'(out_valid[0]), 0);
    tick();
    chk("clear-cycle prod_ready", int'(prod_ready[0]), 0);
    chk("clear-cycle out_valid", int'(out_valid[0]), 1);
    chk("clear-cycle acc_rst", int'(acc_rst[0]), 1);
    chk("clear-cycle score", int'(score[0]), 32768);
    tick();
    chk("back-to-acc out_valid", int'(out_valid[0]), 0);
    chk("back-to-acc prod_ready", int'(prod_ready[0]), 1);
    repeat (2) tick();
    check_vec("pos4", 1'b1, 32768, 4);

    for (int k = 0; k < 8; k++) begin
      tv[0] = tbl[k].t0; tv[1] = tbl[k].t1; tv[2] = tbl[k].t2; tv[3] = tbl[k].t3;
      if (tbl[k].mal) exp_ferr = 1;
      run_vec(tbl[k].n, tbl[k].last_idx, tbl[k].gap, tbl[k].abrt);
      check_vec($sformatf("tbl%0d", k), tbl[k].good, tbl[k].sum, tbl[k].n);
    end

    // Reset mid-vector drops the partial sum and clears the sticky error.
    snap();
    send_term(8192, 1'b0, 0);
    send_term(8192, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int j = 0; j < NI; j++) begin
      exp_score[j] = 0;
      exp_car[j]   = 0;
    end
    exp_ferr = 0;
    check_vec("midrst", 1'b0, 0, 2);
    tv = '{8192, 8192, 8192, 8192};
    run_vec(4, 3, 0, 1'b0);
    check_vec("after-rst", 1'b1, 32768, 4);

    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) tv[i] = int'($urandom_range(131071, 0)) - 65536;
      if (kind <= 1) begin
        sum = 0;
        for (int i = 0; i < 4; i++) sum += tv[i];
        run_vec(4, 3, $urandom_range(2, 0), 1'b0);
        check_vec($sformatf("rnd%0d-good", r), 1'b1, sum, 4);
      end else if (kind == 2) begin
        n = $urandom_range(3, 1);
        exp_ferr = 1;
        run_vec(n, n - 1, $urandom_range(2, 0), 1'b0);
        check_vec($sformatf("rnd%0d-early", r), 1'b0, 0, n);
      end else if (kind == 3) begin
        exp_ferr = 1;
        run_vec(4, -1, $urandom_range(2, 0), 1'b0);
        check_vec($sformatf("rnd%0d-nolast", r), 1'b0, 0, 4);
      end else begin
        n = $urandom_range(3, 0);
        run_vec(n, -1, $urandom_range(2, 0), 1'b1);
        check_vec($sformatf("rnd%0d-abort", r), 1'b0, 0, n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_decision.md
Name: svm_decision

Overview:
- Downstream consumer and sequencer for the SVM accumulator (acc_svm) in the LiDAR car-detection datapath.
- Drives the accumulator's ce/rst.
- Counts N_FEAT product terms per feature vector.
- Captures the completed dot product, adds the bias, thresholds at zero and emits a one-cycle car/no-car decision.
- Clears the accumulator for the next vector and flags malformed vectors.

Parameters:
- N_FEAT, 64: number of product terms per feature vector (≥2).
- BIAS, 22'sd0: SVM bias, signed s8c13f, same format as the accumulator output.
- CW, $clog2(N_FEAT): width of the term counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- prod_valid  input  1  upstream product term valid this cycle.
- prod_last  input  1  upstream marks the final term of a vector; qualified by prod_valid.
- prod_ready  output  1  block accepts a term this cycle.
- abort  input  1  drop the current vector.
- acc_y  input  22  accumulator output, s8c13f.
- acc_ce  output  1  accumulator clock enable.
- acc_rst  output  1  accumulator synchronous clear.
- score  output  23  acc_y + BIAS, s9c13f, registered.
- is_car  output  1  score ≥ 0, registered.
- out_valid  output  1  one-cycle pulse: score and is_car are new.
- frame_err  output  1  sticky malformed-vector flag; cleared only by rst.

Behaviour:
- Reset (rst=1, synchronous) sets:
  - state=ACC, count=0;
  - score=0, is_car=0, out_valid=0, frame_err=0;
  - acc_rst=1, acc_ce=1 (accumulator cleared in the same cycle).
- Accepted term: prod_valid & prod_ready.
- State ACC:
  - prod_ready=1; acc_ce=prod_valid; acc_rst=0.
  - Each accepted term increments count.
  - Accepted term with count==N_FEAT-1 and prod_last=1 → SCORE.
  - Accepted term with count==N_FEAT-1 and prod_last=0 → frame_err←1, go to CLEAR, no output.
  - Accepted term with prod_last=1 and count<N_FEAT-1 → frame_err←1, go to CLEAR, no output. That term is still added; the sum is discarded.
  - abort=1 (any cycle in ACC) → CLEAR; the term presented that cycle is not accumulated (acc_ce=0); frame_err unchanged.
- State SCORE (1 cycle):
  - prod_ready=0, acc_ce=0.
  - acc_y now holds the full sum because the accumulator latency is 0 after the last ce edge.
  - Registers score←sign-extended acc_y + sign-extended BIAS (23-bit, cannot overflow).
  - Registers is_car←~sum[22], so zero counts as car.
  - Sets out_valid←1.
  - abort is ignored.
  - → CLEAR.
- State CLEAR (1 cycle):
  - prod_ready=0; acc_rst=1, acc_ce=1; count←0.
  - out_valid is high in this cycle for a SCORE→CLEAR path, low otherwise.
  - → ACC.
- out_valid is registered and high for exactly one cycle per good vector.
- score and is_car hold their values until the next good vector; they are not altered by error/abort paths.
- Throughput: N_FEAT accepted terms + 2 bubble cycles per vector.
- rst mid-vector or mid-SCORE: the partial sum is lost, no out_valid is produced, and the next vector starts from count=0.
- frame_err never clears except by rst.

Decomposition:
- Package svm_pkg holds:
  - ACC_W=22, SCORE_W=23, FRAC=13;
  - state encoding ACC/SCORE/CLEAR (2-bit localparams);
  - default N_FEAT and BIAS.
- No sub-module is needed: a single FSM plus counter plus output registers.
- The accumulator stays external (acc_svm) and is instantiated beside this block at the next level up.

Test Plan:
- Normal positive vector:
  - Setup: N_FEAT=4, BIAS=0.
  - Stimulus: 4 back-to-back terms 17'sh02000 (1.0), last on the 4th.
  - Required response: out_valid pulses exactly once, 2 cycles after the 4th accept; score=23'sd32768 (4.0), is_car=1; acc_rst seen next cycle; prod_ready low for 2 cycles.
- Negative with bias:
  - Setup: BIAS=22'sd8192 (+1.0).
  - Stimulus: 4 terms -4096 (-0.5).
  - Required response: score=-8192, is_car=0.
  - Zero boundary: a single case with terms summing to -BIAS gives score=0, is_car=1.
- Gapped input:
  - Stimulus: the same terms as scenario 1 with prod_valid deasserted for 3 random cycles between terms.
  - Required response: identical result (score=32768), no spurious acc_ce.
- Malformed vector:
  - Stimulus: prod_last on the 3rd term.
  - Required response: frame_err=1, no out_valid, accumulator cleared.
  - Follow-up: the next correct 4-term vector gives the correct score and frame_err stays 1.
- Abort and reset mid-vector:
  - Abort after 2 terms → no output, the next vector scores correctly.
  - Separately, rst after 2 terms → all outputs 0, the next vector scores correctly.
- Range check:
  - Stimulus: 4 terms 17'sh0FFFF (max positive) with BIAS=22'sh1FFFFF.
  - Required response: score = 262140 + 2097151 = 2359291, exact, no wrap; is_car=1.
